// File: rtl/countup_nbits.sv
// rtl/countup_nbits.sv - N-bit up counter with prescaler, pause, wrap/halt modes and hex display
//
// Purpose: counts from 0 up to a limit captured at start, one step per
// TICK_DIV clock cycles. At the limit it either rolls over (wrap=1) or halts
// (wrap=0), and it pulses done for one cycle at each terminal event.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   start from IDLE/DONE, resume from PAUSE
//   stop     in   pause while running
//   clear    in   return to IDLE with count 0
//   wrap     in   1 = roll over at limit, 0 = halt at limit
//   limit    in   [N-1:0] terminal count, captured at start
//   countOut out  [N-1:0] registered count
//   running  out  registered, high in RUN
//   done     out  registered one-cycle terminal pulse
//   led1     out  [6:0] active-low {g,f,e,d,c,b,a} of countOut[3:0]
//   led2     out  [6:0] active-low {g,f,e,d,c,b,a} of countOut[N-1:4]
module countup_nbits #(
  parameter int N        = 6,
  parameter int TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         wrap,
  input  logic [N-1:0] limit,
  output logic [N-1:0] countOut,
  output logic         running,
  output logic         done,
  output logic [6:0]   led1,
  output logic [6:0]   led2
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [N-1:0]  count_q,   count_d;
  logic [N-1:0]  limit_q,   limit_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic          done_q,    done_d;
  logic          running_q, running_d;
  logic          tick;
  logic [3:0]    hi_digit;

  // With TICK_DIV=1 the prescaler stays at 0 and every RUN cycle ticks.
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // stop outranks start even though it has no effect here
          if (start && !stop) begin
            state_d = S_RUN;
            count_d = '0;
            presc_d = '0;
            limit_d = limit;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            presc_d = '0;
            if (count_q != limit_q) begin
              count_d = count_q + N'(1);
            end else begin
              done_d = 1'b1;
              if (wrap) begin
                count_d = '0;
              end else begin
                state_d = S_DONE;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (start && !stop) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Upper digit: bits above 3, zero-extended into a nibble.
  assign hi_digit = 4'(count_q >> 4);

  assign countOut = count_q;
  assign running  = running_q;
  assign done     = done_q;
  assign led1     = seg7(count_q[3:0]);
  assign led2     = seg7(hi_digit);

endmodule

// File: tb/tb_countup_nbits.sv
// tb/tb_countup_nbits.sv - directed self-checking bench for countup_nbits
module tb_countup_nbits;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset, start, stop, clear, wrap;
  logic [N-1:0] limit;

  logic [N-1:0] a_count, b_count;
  logic         a_running, b_running, a_done, b_done;
  logic [6:0]   a_led1, a_led2, b_led1, b_led2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  countup_nbits #(.N(N), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .wrap(wrap), .limit(limit), .countOut(a_count), .running(a_running),
    .done(a_done), .led1(a_led1), .led2(a_led2)
  );

  countup_nbits #(.N(N), .TICK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .wrap(wrap), .limit(limit), .countOut(b_count), .running(b_running),
    .done(b_done), .led1(b_led1), .led2(b_led2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int seq_b[8];
    seq_b = '{0, 0, 1, 1, 2, 2, 3, 3};

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; wrap = 1'b0;
    limit = '0;
    step(2);
    reset = 1'b0;

    // reset state
    check("rst_count",   a_count,   0);
    check("rst_running", a_running, 0);
    check("rst_done",    a_done,    0);
    check("rst_led1",    a_led1,    7'b1000000);
    check("rst_led2",    a_led2,    7'b1000000);

    // TICK_DIV=2, limit=3, halt mode
    limit = 6'd3; wrap = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("div2_count_%0d", i), b_count, seq_b[i]);
      check($sformatf("div2_done_%0d", i), b_done, 0);
      step();
    end
    check("div2_term_running", b_running, 0);
    check("div2_term_done",    b_done,    1);
    check("div2_term_count",   b_count,   3);
    step();
    check("div2_after_done",   b_done,    0);
    check("div2_hold_count",   b_count,   3);

    // TICK_DIV=1, limit=2, wrap mode
    do_clear();
    limit = 6'd2; wrap = 1'b1;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("wrap_count_%0d", i), a_count, i % 3);
      check($sformatf("wrap_done_%0d", i), a_done, (i > 0 && i % 3 == 0) ? 1 : 0);
      check($sformatf("wrap_running_%0d", i), a_running, 1);
      step();
    end

    // pause / resume
    do_clear();
    limit = 6'd20; wrap = 1'b0;
    pulse_start();
    step(5);
    check("pause_pre_count", a_count, 5);
    check("pause_led1", a_led1, 7'b0010010);
    check("pause_led2", a_led2, 7'b1000000);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("pause_running", a_running, 0);
    check("pause_count0", a_count, 5);
    step(10);
    check("pause_count10", a_count, 5);
    pulse_start();
    check("resume_running", a_running, 1);
    check("resume_count", a_count, 5);
    step();
    check("resume_next", a_count, 6);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("stopstart_running", a_running, 0);
    check("stopstart_count", a_count, 6);
    step();
    check("stopstart_frozen", a_count, 6);

    // full-range roll over
    do_clear();
    limit = 6'd63; wrap = 1'b1;
    pulse_start();
    step(63);
    check("roll_count63", a_count, 63);
    check("roll_led1_F",  a_led1, 7'b0001110);
    check("roll_led2_3",  a_led2, 7'b0110000);
    check("roll_done_pre", a_done, 0);
    step();
    check("roll_count0",  a_count, 0);
    check("roll_done",    a_done, 1);
    check("roll_running", a_running, 1);
    check("roll_led1_0",  a_led1, 7'b1000000);
    check("roll_led2_0",  a_led2, 7'b1000000);

    // limit change after capture is ignored
    do_clear();
    limit = 6'd3; wrap = 1'b0;
    pulse_start();
    limit = 6'd10;
    step(3);
    check("cap_count3", a_count, 3);
    check("cap_done_pre", a_done, 0);
    step();
    check("cap_done", a_done, 1);
    check("cap_count_hold", a_count, 3);
    check("cap_running", a_running, 0);

    // start+clear together: clear wins
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    check("startclear_count", a_count, 0);
    check("startclear_running", a_running, 0);
    step();
    check("startclear_idle", a_count, 0);

    // reset mid-RUN at count 2, on what would be a terminal tick
    limit = 6'd2; wrap = 1'b0;
    pulse_start();
    step(2);
    check("rstrun_pre_count", a_count, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstrun_count",   a_count,   0);
    check("rstrun_running", a_running, 0);
    check("rstrun_done",    a_done,    0);
    step();
    check("rstrun_idle", a_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countup_nbits.md
COUNTUP_NBITS -- requirements
Module: countup_nbits

Interface
REQ-001 The module SHALL have parameter N, default 6, meaning the counter width in bits; legal range 5..8.
REQ-002 The module SHALL have parameter TICK_DIV, default 1, meaning clock cycles per count step; legal range >=1.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port start  input  1  level; starts or resumes counting.
REQ-006 The module SHALL have port stop  input  1  level; pauses counting.
REQ-007 The module SHALL have port clear  input  1  level; returns the block to idle with count 0.
REQ-008 The module SHALL have port wrap  input  1  mode: 1 = roll over at the limit, 0 = halt at the limit.
REQ-009 The module SHALL have port limit  input  N  terminal count value, captured at start.
REQ-010 The module SHALL have port countOut  output  N  registered current count.
REQ-011 The module SHALL have port running  output  1  high while in state RUN.
REQ-012 The module SHALL have port done  output  1  one-cycle pulse at each terminal event.
REQ-013 The module SHALL have port led1  output  7  seven-segment code of countOut[3:0] as a hex digit.
REQ-014 The module SHALL have port led2  output  7  seven-segment code of countOut[N-1:4], zero-extended to 4 bits, as a hex digit.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-016 Command priority SHALL be reset > clear > stop > start when commands are asserted in the same cycle.
REQ-017 On clear in any state, the next state SHALL be IDLE, with countOut=0, prescaler=0, and done=0.
REQ-018 IDLE SHALL go to RUN on start, with countOut=0 and prescaler=0, and SHALL capture limit into an internal limit register.
REQ-019 DONE SHALL behave as IDLE on start: it restarts from 0 and recaptures limit.
REQ-020 While in RUN, the prescaler SHALL increment every cycle.
REQ-021 When the prescaler equals TICK_DIV-1, the block SHALL generate a tick and the prescaler SHALL return to 0 in the same cycle; with TICK_DIV=1, every RUN cycle is a tick.
REQ-022 On a tick with countOut != captured limit, countOut SHALL increment by 1.
REQ-023 On a tick with countOut == captured limit, done SHALL pulse 1 on the next cycle.
REQ-024 On that terminal tick, if wrap=1 then countOut SHALL become 0 and the state SHALL stay RUN.
REQ-025 On that terminal tick, if wrap=0 then countOut SHALL hold at limit and the state SHALL go to DONE.
REQ-026 wrap SHALL be sampled at the terminal tick.
REQ-027 The terminal event SHALL occur one full tick period after countOut reaches limit; for limit=0 this is the first tick after start.
REQ-028 Changes on the limit port after capture SHALL be ignored until the next start from IDLE or DONE.
REQ-029 RUN SHALL go to PAUSE on stop.
REQ-030 In PAUSE, countOut and the prescaler SHALL be frozen, and start SHALL return the block to RUN with the prescaler value preserved.
REQ-031 start while in RUN SHALL be ignored, and stop in IDLE, PAUSE, or DONE SHALL be ignored.
REQ-032 The counter SHALL be N bits; with limit = 2**N-1 and wrap=1, it SHALL roll from 2**N-1 to 0 with no overflow state.
REQ-033 countOut, running, and done SHALL all be registered outputs.
REQ-034 led1 and led2 SHALL be combinational functions of countOut.
REQ-035 Segment encoding SHALL be bit order {g,f,e,d,c,b,a}, active-low, covering hex digits 0-F (e.g. 0 -> 7'b1000000, 1 -> 7'b1111001, F -> 7'b0001110).

Reset
REQ-036 On reset, the state SHALL be IDLE, and countOut, the prescaler, and the captured limit SHALL be 0.
REQ-037 On reset, running and done SHALL be 0, and led1 and led2 SHALL both display 0 (7'b1000000).
REQ-038 Reset asserted mid-RUN SHALL abort the current count and suppress any pending done pulse.

Verification
REQ-039 With TICK_DIV=2, limit=3, wrap=0: a 1-cycle start SHALL yield countOut 0,0,1,1,2,2,3,3, then the state SHALL be DONE, done SHALL be high for one cycle, and countOut SHALL hold at 3.
REQ-040 With TICK_DIV=1, limit=2, wrap=1: countOut SHALL repeat 0,1,2,0,1,2, done SHALL pulse once per 3 cycles, and running SHALL stay 1.
REQ-041 With TICK_DIV=1 in RUN: stop at count 5 SHALL freeze count 5 for 10 cycles; a following start SHALL resume at 6; stop+start in the same cycle SHALL result in PAUSE.
REQ-042 With limit=63, wrap=1, TICK_DIV=1: after count 63 the next value SHALL be 0 with a done pulse, and led2/led1 SHALL show 3/F (7'b0110000/7'b0001110) before rolling to 0/0.
REQ-043 Changing limit from 3 to 10 during RUN SHALL still terminate at 3; start+clear in the same cycle SHALL result in IDLE with count 0.
REQ-044 Reset asserted while in RUN at count 2 SHALL produce, on the next cycle, IDLE with countOut=0, running=0, and done=0.
